knight_rider_scanner: RTL and testbench

Parametrised "Knight Rider" LED scanner: a single lit head sweeps across an `N_LEDS`-wide LED bar, followed by a fading PWM tail of `TAIL_LEN` positions. The block adds run-time scan modes, speed selection, pause, and status outputs. It sits between the board clock and the LED pins, and replaces the fixed 8-LED, fixed-pattern scanner.

---
 rtl/knight_rider_pkg.sv | 23 ++
 rtl/step_tick_gen.sv | 45 ++++
 rtl/knight_rider_scanner.sv | 164 ++++++++++++++++
 tb/tb_knight_rider_scanner.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knight_rider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : knight_rider_pkg
//  Description : Shared scan-mode encodings and direction constants for the
//                Knight Rider LED scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
package knight_rider_pkg;

    // Run-time scan modes; the reserved code behaves as bounce
    typedef enum logic [1:0] {
        MODE_BOUNCE  = 2'b00,
        MODE_WRAP_UP = 2'b01,
        MODE_WRAP_DN = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    // Direction of head travel
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage : knight_rider_pkg
`default_nettype wire

// File: rtl/step_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : step_tick_gen
//  Description : Prescaler producing one step tick every (CLK_DIV >> speed)
//                clock cycles while enabled; the count is held while paused.
//  Revision    : 1.0 - initial release
// ============================================================================
module step_tick_gen #(
    parameter int CLK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] speed,
    output logic       tick
);

    localparam int c_cnt_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [c_cnt_w-1:0] r_div_cnt;
    logic [31:0]        w_limit;
    logic               w_reached;

    // Terminal count compare; >= lets a mid-count speed-up fire immediately
    always_comb begin
        w_limit   = 32'(CLK_DIV >> speed) - 32'd1;
        w_reached = (32'(r_div_cnt) >= w_limit);
    end

    // Pausing gates the tick in the same cycle
    assign tick = en & w_reached;

    // Prescaler counter: clears on tick, counts while enabled, holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (tick) begin
            r_div_cnt <= '0;
        end else if (en) begin
            r_div_cnt <= r_div_cnt + c_cnt_w'(1);
        end
    end

endmodule : step_tick_gen
`default_nettype wire

// File: rtl/knight_rider_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : knight_rider_scanner
//  Description : Sweeping LED head with a PWM-faded tail, selectable bounce /
//                wrap-up / wrap-down scan, speed select, pause and status.
//  Revision    : 1.0 - initial release
// ============================================================================
module knight_rider_scanner
    import knight_rider_pkg::*;
#(
    parameter int N_LEDS    = 8,
    parameter int TAIL_LEN  = 2,
    parameter int CLK_DIV   = 12_500_000,
    parameter int PWM_BITS  = 4,
    parameter int START_POS = 0,
    parameter int DIR_INIT  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [1:0]                mode,
    input  logic [1:0]                speed,
    output logic [N_LEDS-1:0]         led_out,
    output logic [$clog2(N_LEDS)-1:0] pos,
    output logic                      dir,
    output logic                      edge_hit
);

    localparam int                 c_pos_w = $clog2(N_LEDS);
    localparam logic [c_pos_w-1:0] c_last  = c_pos_w'(N_LEDS - 1);
    localparam logic [c_pos_w-1:0] c_one   = c_pos_w'(1);
    localparam logic [c_pos_w-1:0] c_start = c_pos_w'(START_POS);

    logic                w_tick;
    logic [c_pos_w-1:0]  r_pos,  w_pos_nxt;
    logic                r_dir,  w_dir_nxt;
    logic                r_edge, w_edge_nxt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [N_LEDS-1:0]   w_head_mask;
    logic [N_LEDS-1:0]   w_tail_mask;
    logic [N_LEDS-1:0]   r_led;

    step_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_step_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .speed (speed),
        .tick  (w_tick)
    );

    // Head position/direction next-state; in bounce the direction turns on
    // arrival at an end so dir always points where the head goes next
    always_comb begin
        w_pos_nxt  = r_pos;
        w_dir_nxt  = r_dir;
        w_edge_nxt = 1'b0;
        if (w_tick) begin
            case (mode_e'(mode))
                MODE_WRAP_UP: begin
                    w_dir_nxt = DIR_UP;
                    w_pos_nxt = (r_pos == c_last) ? '0 : r_pos + c_one;
                end
                MODE_WRAP_DN: begin
                    w_dir_nxt = DIR_DN;
                    w_pos_nxt = (r_pos == '0) ? c_last : r_pos - c_one;
                end
                default: begin
                    if (r_dir == DIR_UP) begin
                        w_pos_nxt = (r_pos == c_last) ? c_last - c_one : r_pos + c_one;
                    end else begin
                        w_pos_nxt = (r_pos == '0) ? c_one : r_pos - c_one;
                    end
                    if (w_pos_nxt == c_last) begin
                        w_dir_nxt = DIR_DN;
                    end else if (w_pos_nxt == '0) begin
                        w_dir_nxt = DIR_UP;
                    end else if (r_pos == c_last) begin
                        w_dir_nxt = DIR_DN;
                    end else if (r_pos == '0) begin
                        w_dir_nxt = DIR_UP;
                    end
                end
            endcase
            w_edge_nxt = (w_pos_nxt == '0) || (w_pos_nxt == c_last);
        end
    end

    // Head state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos  <= c_start;
            r_dir  <= 1'(DIR_INIT);
            r_edge <= 1'b0;
        end else begin
            r_pos  <= w_pos_nxt;
            r_dir  <= w_dir_nxt;
            r_edge <= w_edge_nxt;
        end
    end

    // Free-running PWM phase counter, independent of pause
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
        end
    end

    generate
        if (TAIL_LEN > 0) begin : g_tail
            logic [TAIL_LEN-1:0]              r_tail_vld;
            logic [TAIL_LEN-1:0][c_pos_w-1:0] r_tail_pos;

            // Tail history: entry 0 holds the previous head, older ones follow
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tail_vld <= '0;
                    r_tail_pos <= '0;
                end else if (w_tick) begin
                    for (int i = TAIL_LEN - 1; i > 0; i--) begin
                        r_tail_vld[i] <= r_tail_vld[i-1];
                        r_tail_pos[i] <= r_tail_pos[i-1];
                    end
                    r_tail_vld[0] <= 1'b1;
                    r_tail_pos[0] <= r_pos;
                end
            end

            // Tail entry k+1 lights for the first 2**PWM_BITS >> (k+1) phases
            always_comb begin
                w_tail_mask = '0;
                for (int k = 0; k < TAIL_LEN; k++) begin
                    if (r_tail_vld[k] &&
                        (32'(r_pwm_cnt) < ((32'd1 << PWM_BITS) >> (k + 1)))) begin
                        w_tail_mask = w_tail_mask | (N_LEDS'(1) << r_tail_pos[k]);
                    end
                end
            end
        end else begin : g_no_tail
            assign w_tail_mask = '0;
        end
    endgenerate

    assign w_head_mask = N_LEDS'(1) << r_pos;

    // Registered LED drive; head and tail are OR-combined
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= '0;
        end else begin
            r_led <= w_head_mask | w_tail_mask;
        end
    end

    assign led_out  = r_led;
    assign pos      = r_pos;
    assign dir      = r_dir;
    assign edge_hit = r_edge;

endmodule : knight_rider_scanner
`default_nettype wire

// File: tb/tb_knight_rider_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_knight_rider_scanner
//  Description : Self-checking bench for knight_rider_scanner with a
//                behavioural reference model and randomized stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_knight_rider_scanner;

    localparam int N        = 4;
    localparam int CLK_DIV  = 8;
    localparam int TAIL_LEN = 2;
    localparam int PWM_BITS = 2;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [1:0] speed;
    logic [3:0] led_out;
    logic [1:0] pos;
    logic       dir;
    logic       edge_hit;

    int n_vec;
    int n_err;

    // reference model state
    int         m_cnt;
    int         m_pos;
    bit         m_dir;
    bit         m_edge;
    int         m_pwm;
    logic [3:0] m_led;
    int         m_hist[$];

    knight_rider_scanner #(
        .N_LEDS    (N),
        .TAIL_LEN  (TAIL_LEN),
        .CLK_DIV   (CLK_DIV),
        .PWM_BITS  (PWM_BITS),
        .START_POS (0),
        .DIR_INIT  (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .speed    (speed),
        .led_out  (led_out),
        .pos      (pos),
        .dir      (dir),
        .edge_hit (edge_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_cnt  = 0;
        m_pos  = 0;
        m_dir  = 1'b1;
        m_edge = 1'b0;
        m_pwm  = 0;
        m_led  = 4'b0000;
        m_hist.delete();
    endtask

    // Advance the model by one clock using the current inputs, then clock the DUT
    task automatic advance();
        int         period;
        int         old_pos;
        bit         tk;
        logic [3:0] nl;
        period = CLK_DIV >> speed;
        tk     = en && (m_cnt >= period - 1);
        nl     = 4'(1 << m_pos);
        for (int k = 1; k <= m_hist.size(); k++)
            if (m_pwm < ((1 << PWM_BITS) >> k)) nl |= 4'(1 << m_hist[k-1]);
        m_led  = nl;
        m_edge = 1'b0;
        if (tk) begin
            m_hist.push_front(m_pos);
            if (m_hist.size() > TAIL_LEN) void'(m_hist.pop_back());
            old_pos = m_pos;
            case (mode)
                2'd1: begin m_dir = 1'b1; m_pos = (m_pos + 1) % N; end
                2'd2: begin m_dir = 1'b0; m_pos = (m_pos + N - 1) % N; end
                default: begin
                    if (m_dir) m_pos = (m_pos == N - 1) ? N - 2 : m_pos + 1;
                    else       m_pos = (m_pos == 0) ? 1 : m_pos - 1;
                    if (m_pos == N - 1)  m_dir = 1'b0;
                    else if (m_pos == 0) m_dir = 1'b1;
                    else                 m_dir = (m_pos > old_pos);
                end
            endcase
            m_edge = (m_pos == 0) || (m_pos == N - 1);
            m_cnt  = 0;
        end else if (en) begin
            m_cnt++;
        end
        m_pwm = (m_pwm + 1) % (1 << PWM_BITS);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'd0;
        speed = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({led_out, pos, dir, edge_hit} !== {4'b0000, 2'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state got led=%b pos=%0d dir=%b edge=%b exp led=0000 pos=0 dir=1 edge=0",
                     led_out, pos, dir, edge_hit);
        end
        en = 1'b1; mode = 2'd0; speed = 2'd0;
        model_reset();
        rst_n = 1'b1;
        advance();
        n_vec++;
        if (led_out !== 4'b0001) begin
            n_err++;
            $display("FAIL first_led got %b exp 0001", led_out);
        end
    endtask

    task automatic test_bounce();
        int exp_pos[7]  = '{1, 2, 3, 2, 1, 0, 1};
        bit exp_dir[7]  = '{1, 1, 0, 0, 0, 1, 1};
        bit exp_edge[7] = '{0, 0, 1, 0, 0, 1, 0};
        apply_reset();
        en = 1'b1; mode = 2'd0; speed = 2'd0;
        for (int i = 0; i < 7; i++) begin
            for (int c = 0; c < 8; c++) begin
                advance();
                n_vec++;
                if ({led_out, pos, dir, edge_hit} !== {m_led, 2'(m_pos), m_dir, m_edge}) begin
                    n_err++;
                    $display("FAIL bounce_model got %b/%0d/%b/%b exp %b/%0d/%b/%b",
                             led_out, pos, dir, edge_hit, m_led, m_pos, m_dir, m_edge);
                end
            end
            n_vec++;
            if ({pos, dir, edge_hit} !== {2'(exp_pos[i]), exp_dir[i], exp_edge[i]}) begin
                n_err++;
                $display("FAIL bounce_step%0d got pos=%0d dir=%b edge=%b exp pos=%0d dir=%b edge=%b",
                         i, pos, dir, edge_hit, exp_pos[i], exp_dir[i], exp_edge[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int exp_pos[9]  = '{1, 2, 3, 0, 1, 2, 1, 0, 3};
        bit exp_dir[9]  = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
        bit exp_edge[9] = '{0, 0, 1, 1, 0, 0, 0, 1, 1};
        apply_reset();
        en = 1'b1; mode = 2'd1; speed = 2'd0;
        for (int i = 0; i < 9; i++) begin
            if (i == 6) mode = 2'd2;
            for (int c = 0; c < 8; c++) begin
                advance();
                n_vec++;
                if ({led_out, pos, dir, edge_hit} !== {m_led, 2'(m_pos), m_dir, m_edge}) begin
                    n_err++;
                    $display("FAIL wrap_model got %b/%0d/%b/%b exp %b/%0d/%b/%b",
                             led_out, pos, dir, edge_hit, m_led, m_pos, m_dir, m_edge);
                end
            end
            n_vec++;
            if ({pos, dir, edge_hit} !== {2'(exp_pos[i]), exp_dir[i], exp_edge[i]}) begin
                n_err++;
                $display("FAIL wrap_step%0d got pos=%0d dir=%b edge=%b exp pos=%0d dir=%b edge=%b",
                         i, pos, dir, edge_hit, exp_pos[i], exp_dir[i], exp_edge[i]);
            end
        end
    endtask

    task automatic test_tail();
        int on_cnt[4];
        int exp_cnt[4] = '{1, 2, 4, 0};
        apply_reset();
        en = 1'b1; mode = 2'd0; speed = 2'd0;
        repeat (16) advance();
        en = 1'b0;
        advance();
        for (int b = 0; b < 4; b++) on_cnt[b] = 0;
        for (int c = 0; c < 4; c++) begin
            for (int b = 0; b < 4; b++) if (led_out[b] === 1'b1) on_cnt[b]++;
            n_vec++;
            if (led_out !== m_led) begin
                n_err++;
                $display("FAIL tail_model got %b exp %b", led_out, m_led);
            end
            advance();
        end
        for (int b = 0; b < 4; b++) begin
            n_vec++;
            if (on_cnt[b] !== exp_cnt[b]) begin
                n_err++;
                $display("FAIL tail_duty led%0d got %0d/4 exp %0d/4", b, on_cnt[b], exp_cnt[b]);
            end
        end
    endtask

    task automatic test_speed();
        apply_reset();
        en = 1'b1; mode = 2'd0; speed = 2'd2;
        advance();
        n_vec++;
        if (pos !== 2'd0) begin n_err++; $display("FAIL speed_hold got pos=%0d exp 0", pos); end
        advance();
        n_vec++;
        if (pos !== 2'd1) begin n_err++; $display("FAIL speed_tick got pos=%0d exp 1", pos); end
        for (int c = 0; c < 6; c++) begin
            advance();
            n_vec++;
            if ({led_out, pos, dir, edge_hit} !== {m_led, 2'(m_pos), m_dir, m_edge}) begin
                n_err++;
                $display("FAIL speed_model got %b/%0d/%b/%b exp %b/%0d/%b/%b",
                         led_out, pos, dir, edge_hit, m_led, m_pos, m_dir, m_edge);
            end
        end
        n_vec++;
        if (pos !== 2'd2) begin n_err++; $display("FAIL speed_seq got pos=%0d exp 2", pos); end
        // speed-up mid-count with div_cnt at 5
        apply_reset();
        en = 1'b1; mode = 2'd0; speed = 2'd0;
        repeat (5) advance();
        speed = 2'd2;
        advance();
        n_vec++;
        if (pos !== 2'd1) begin n_err++; $display("FAIL speed_change got pos=%0d exp 1", pos); end
    endtask

    task automatic test_pause();
        int led0_on;
        apply_reset();
        en = 1'b1; mode = 2'd0; speed = 2'd0;
        repeat (11) advance();
        en = 1'b0;
        led0_on = 0;
        for (int c = 0; c < 20; c++) begin
            advance();
            if (led_out[0] === 1'b1) led0_on++;
            n_vec++;
            if ({led_out, pos, dir, edge_hit} !== {m_led, 2'(m_pos), m_dir, m_edge}) begin
                n_err++;
                $display("FAIL pause_model got %b/%0d/%b/%b exp %b/%0d/%b/%b",
                         led_out, pos, dir, edge_hit, m_led, m_pos, m_dir, m_edge);
            end
        end
        n_vec++;
        if (led0_on !== 10) begin n_err++; $display("FAIL pause_pwm got %0d/20 exp 10/20", led0_on); end
        en = 1'b1;
        repeat (4) advance();
        n_vec++;
        if (pos !== 2'd1) begin n_err++; $display("FAIL pause_remain got pos=%0d exp 1", pos); end
        advance();
        n_vec++;
        if (pos !== 2'd2) begin n_err++; $display("FAIL pause_resume got pos=%0d exp 2", pos); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        en = 1'b1; mode = 2'd0; speed = 2'd0;
        repeat (20) advance();
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({led_out, pos, dir, edge_hit} !== {4'b0000, 2'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset got led=%b pos=%0d dir=%b edge=%b exp 0000/0/1/0",
                     led_out, pos, dir, edge_hit);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 7; c++) begin
            advance();
            n_vec++;
            if (led_out !== 4'b0001) begin
                n_err++;
                $display("FAIL post_reset_led cycle%0d got %b exp 0001", c, led_out);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        en = 1'b1; mode = 2'd0; speed = 2'd0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) en = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) speed = 2'($urandom_range(0, 3));
            advance();
            n_vec++;
            if ({led_out, pos, dir, edge_hit} !== {m_led, 2'(m_pos), m_dir, m_edge}) begin
                n_err++;
                $display("FAIL random_model cyc%0d got %b/%0d/%b/%b exp %b/%0d/%b/%b",
                         c, led_out, pos, dir, edge_hit, m_led, m_pos, m_dir, m_edge);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'd0;
        speed = 2'd0;
        model_reset();
        test_reset();
        test_bounce();
        test_wrap();
        test_tail();
        test_speed();
        test_pause();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_knight_rider_scanner
`default_nettype wire
